serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have a port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-004 The block SHALL have a port pattern, input, 8 bits: bits to transmit, captured on accepted start.
REQ-005 The block SHALL have a port len, input, 4 bits: frame length in bits, captured on accepted start; values 1..8 are valid.
REQ-006 The block SHALL have a port rep, input, 1 bit: repeat mode, captured on accepted start.
REQ-007 The block SHALL have a port stop, input, 1 bit: clears captured repeat mode at any cycle.
REQ-008 The block SHALL have a port a, output, 1 bit: registered serial bit stream, driving a sequence-detector input.
REQ-009 The block SHALL have a port valid, output, 1 bit: a carries a frame bit this cycle.
REQ-010 The block SHALL have a port busy, output, 1 bit: high in SHIFT and DONE.
REQ-011 The block SHALL have a port done, output, 1 bit: single-cycle pulse at end of transmission.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL capture pattern, len and rep, enter SHIFT, and present a=pattern[L-1] with valid=1 after that same edge (latency 1 cycle).
REQ-014 The effective length L SHALL be len for len in 1..8; len=0 and len>8 SHALL be treated as L=8.
REQ-015 Bits SHALL be sent MSB-first from bit L-1 down to bit 0, one bit per clock, each held exactly one cycle.
REQ-016 A 3-bit down counter SHALL track remaining bits; on the edge after bit 0, if captured rep=1 the block SHALL remain in SHIFT and present bit L-1 of the captured pattern with no gap cycle.
REQ-017 If captured rep=0 on the edge after bit 0, the block SHALL enter DONE: a=0, valid=0, busy=1, done=1 for one cycle, then IDLE.
REQ-018 stop=1 SHALL clear captured rep on the next edge; the current frame SHALL complete in full and then go to DONE.
REQ-019 start SHALL be ignored in SHIFT and DONE; pattern, len and rep changes after capture SHALL have no effect.
REQ-020 In IDLE, a=0, valid=0, busy=0, done=0.
REQ-021 If start and stop are both 1 in IDLE, start SHALL be accepted with rep forced to 0.
REQ-022 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, a=0, valid=0, busy=0, done=0, counter=0, captured registers=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no done pulse SHALL be generated.
REQ-025 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-026 pattern=8'b1011_0001, len=8, rep=0, start pulse -> a=1,0,1,1,0,0,0,1 on 8 consecutive cycles with valid=1, then one cycle done=1, then IDLE.
REQ-027 pattern=8'bxxxx_x101, len=3, rep=1, no stop for 9 cycles -> a=1,0,1,1,0,1,1,0,1 with no gap; stop asserted during the 3rd frame -> that frame completes, then done=1.
REQ-028 len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1, then done.
REQ-029 start re-pulsed during SHIFT with a different pattern -> the output stream is unchanged and no restart occurs.
REQ-030 Reset pulsed asynchronously (between edges) at bit 4 of an 8-bit frame -> outputs go 0 immediately, with no done pulse; a new start then transmits correctly.
REQ-031 len=1, pattern=8'h01, rep=0 -> a single cycle of a=1 with valid=1, followed by done=1 on the next cycle.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured 1..8-bit pattern MSB-first onto a, optionally repeating.
// Latency 1 cycle from accepted start to first bit; start is ignored while busy; all outputs registered.
module serial_pattern_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] pattern,
    input  logic [3:0] len,
    input  logic       rep,
    input  logic       stop,
    output logic       a,
    output logic       valid,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] pat_q;
    logic [2:0] top_q;
    logic       rep_q;
    logic [2:0] cnt, cnt_nxt;

    logic [3:0] len_m1;
    logic [2:0] top_in;
    logic       accept, rep_eff, last_bit, bit_nxt;
    logic       a_nxt, valid_nxt, busy_nxt, done_nxt;

    // Index of the first (MSB) bit to send; out-of-range lengths send all 8 bits.
    assign len_m1   = len - 4'd1;
    assign top_in   = (len == 4'd0 || len > 4'd8) ? 3'd7 : len_m1[2:0];
    assign accept   = (state == IDLE) && start;
    assign rep_eff  = rep_q && !stop;
    assign last_bit = (state == SHIFT) && (cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd0 && !rep_eff) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        bit_nxt = 1'b0;
        if (accept) begin
            cnt_nxt = top_in;
            bit_nxt = pattern[top_in];
        end else if (state == SHIFT && cnt != 3'd0) begin
            cnt_nxt = cnt - 3'd1;
            bit_nxt = pat_q[cnt - 3'd1];
        end else if (last_bit && rep_eff) begin
            cnt_nxt = top_q;
            bit_nxt = pat_q[top_q];
        end else if (state != IDLE) begin
            cnt_nxt = 3'd0;
        end
    end

    // Output values are decoded from the next state so they can be registered.
    always_comb begin
        a_nxt     = 1'b0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_nxt)
            SHIFT: begin
                a_nxt     = bit_nxt;
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            DONE: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pat_q <= 8'd0;
            top_q <= 3'd0;
            rep_q <= 1'b0;
            cnt   <= 3'd0;
        end else begin
            a     <= a_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                pat_q <= pattern;
                top_q <= top_in;
                rep_q <= rep && !stop;
            end else if (stop) begin
                rep_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed and randomized checks of serial_pattern_tx against a queue-based frame model.
module tb_serial_pattern_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       rep;
    logic       stop;
    logic       a, valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    serial_pattern_tx dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .rep(rep), .stop(stop), .a(a), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 sending, 2 done; pending frame bits in a queue.
    int         m_mode = 0;
    bit         m_q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_rep;
    logic       e_a, e_v, e_b, e_d;

    function automatic void m_load();
        for (int i = m_len - 1; i >= 0; i--) m_q.push_back(m_pat[i]);
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_q.delete(); m_rep = 0;
        e_a = 0; e_v = 0; e_b = 0; e_d = 0;
    endfunction

    function automatic void m_send();
        e_a = m_q.pop_front(); e_v = 1; e_b = 1; e_d = 0;
    endfunction

    function automatic void model_edge();
        case (m_mode)
            0: begin
                if (start) begin
                    m_pat  = pattern;
                    m_len  = (len >= 1 && len <= 8) ? int'(len) : 8;
                    m_rep  = rep && !stop;
                    m_load();
                    m_send();
                    m_mode = 1;
                end else begin
                    e_a = 0; e_v = 0; e_b = 0; e_d = 0;
                end
            end
            1: begin
                if (stop) m_rep = 0;
                if (m_q.size() == 0 && m_rep) m_load();
                if (m_q.size() != 0) m_send();
                else begin
                    e_a = 0; e_v = 0; e_b = 1; e_d = 1;
                    m_mode = 2;
                end
            end
            default: begin
                e_a = 0; e_v = 0; e_b = 0; e_d = 0;
                m_mode = 0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, {a, valid, busy, done}, {e_a, e_v, e_b, e_d});
    endtask

    // Called at posedge+1; asserts reset between edges and checks the immediate effect.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk(tag, {a, valid, busy, done}, 4'b0000);
        #1 reset = 1'b0;
    endtask

    task automatic go(input logic [7:0] p, input logic [3:0] l, input logic r);
        pattern = p; len = l; rep = r; start = 1'b1;
    endtask

    logic [7:0] seen;
    logic [7:0] want;

    initial begin
        reset = 1'b1; start = 0; pattern = 0; len = 0; rep = 0; stop = 0;
        m_reset();
        #12;
        chk("reset_state", {a, valid, busy, done}, 4'b0000);
        reset = 1'b0;
        step("idle_after_reset");

        // MSB-first 8-bit frame, then a single done pulse
        go(8'b1011_0001, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("frame8");
            start = 1'b0;
            seen[7 - i] = a;
        end
        want = 8'b1011_0001;
        chk("frame8_bits", {seen[7:4]}, want[7:4]);
        chk("frame8_bits_lo", {seen[3:0]}, want[3:0]);
        step("frame8_done");
        chk("frame8_done_abs", {a, valid, busy, done}, 4'b0011);
        step("frame8_idle");

        // Repeat mode: three-bit frames back to back, stop during the third frame
        go(8'b1111_0101, 4'd3, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step("rep3");
            start = 1'b0;
            if (i < 8) seen[7 - i] = a;
            stop = (i == 6);
        end
        want = 8'b1011_0110;
        chk("rep3_stream", seen, want);
        stop = 1'b0;
        step("rep3_done");
        chk("rep3_done_abs", {a, valid, busy, done}, 4'b0011);
        step("rep3_idle");

        // len=0 sends all 8 bits; start re-pulsed mid-frame is ignored
        go(8'hA5, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("len0");
            seen[7 - i] = a;
            start = (i == 2);
            pattern = 8'h3C;
            len = 4'd2;
            rep = 1'b1;
        end
        chk("len0_bits", seen, 8'hA5);
        start = 1'b0;
        step("len0_done");
        step("len0_idle");

        // Single-bit frame
        go(8'h01, 4'd1, 1'b0);
        step("len1_bit");
        chk("len1_bit_abs", {a, valid, busy, done}, 4'b1110);
        start = 1'b0;
        step("len1_done");
        step("len1_idle");

        // Start together with stop forces a single frame
        go(8'hC3, 4'd2, 1'b1);
        stop = 1'b1;
        step("start_stop");
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) step("start_stop_tail");

        // Asynchronous reset in the middle of a frame, then a clean frame
        go(8'h5A, 4'd8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("pre_abort");
            start = 1'b0;
        end
        async_reset("abort_outputs");
        step("abort_no_done");
        go(8'h96, 4'd8, 1'b0);
        step("post_abort_first");
        start = 1'b0;
        for (int i = 0; i < 9; i++) step("post_abort");

        // Randomized traffic including oversize lengths, stop and occasional resets
        for (int i = 0; i < 600; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 11) == 0);
            rep     = $urandom_range(0, 1);
            len     = 4'($urandom_range(0, 15));
            pattern = 8'($urandom);
            step("random");
            if ($urandom_range(0, 99) == 0) async_reset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
